event_watchdog: RTL and testbench

Parametrised multi-channel event watchdog for the KnightsTour verification environment. It generalises the per-check fork/timeout pattern into NUM_CH independent hardware channels. Each channel is armed with a cycle budget and watches one DUT event, either as a rising edge or as a level. It reports pass or timeout with the measured latency and keeps a sticky global fail flag naming the first failing channel. It sits beside the DUT in knight-level benches, fed by hierarchical probes such as cal_done, tour_go, start_tour and send_resp.

---
 rtl/event_watchdog.sv | 89 ++++++++
 tb/tb_event_watchdog.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/event_watchdog.sv
// event_watchdog: NUM_CH independent armed watchdogs reporting pass/timeout, latency and a sticky first-fail record.
module event_watchdog #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 20,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       arm,
  input  logic [CNT_W-1:0]        budget,
  input  logic [NUM_CH-1:0]       lvl_mode,
  input  logic [NUM_CH-1:0]       evt,
  input  logic [NUM_CH-1:0]       abort,
  input  logic                    clr_fail,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       pass,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] lat,
  output logic                    any_fail,
  output logic [CH_W-1:0]         first_fail_ch
);
  localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, PASS = 2'd2, FAIL = 2'd3;
  logic [NUM_CH-1:0] fail_now;
  logic [CNT_W-1:0]  bud1;
  logic [CH_W-1:0]   ff_idx;
  assign bud1 = (budget == '0) ? CNT_W'(1) : budget;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt, el, lat_r;
    logic             mode, evt_q, hit, done_r;
    assign hit         = mode ? evt[i] : evt[i] & ~evt_q;
    assign fail_now[i] = st == ARMED && !arm[i] && !abort[i] && !hit && cnt == CNT_W'(1);
    assign busy[i]     = st == ARMED;
    assign pass[i]     = st == PASS;
    assign timeout[i]  = st == FAIL;
    assign done[i]     = done_r;
    assign lat[i*CNT_W +: CNT_W] = lat_r;
    always_ff @(posedge clk)
      if (!rst_n) begin
        st     <= IDLE;
        cnt    <= '0;
        el     <= '0;
        lat_r  <= '0;
        mode   <= 1'b0;
        evt_q  <= 1'b0;
        done_r <= 1'b0;
      end else begin
        evt_q  <= evt[i];
        done_r <= 1'b0;
        if (arm[i]) begin
          st   <= ARMED;
          cnt  <= bud1;
          el   <= '0;
          mode <= lvl_mode[i];
        end else if (abort[i]) begin
          st <= IDLE;
        end else if (st == ARMED) begin
          // a hit on the last budget cycle still counts as a pass
          if (hit) begin
            st     <= PASS;
            done_r <= 1'b1;
            lat_r  <= el + CNT_W'(1);
          end else if (cnt == CNT_W'(1)) begin
            st     <= FAIL;
            done_r <= 1'b1;
            lat_r  <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
            el  <= el + CNT_W'(1);
          end
        end
      end
  end
  always_comb begin
    ff_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (fail_now[i]) ff_idx = CH_W'(i);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      any_fail      <= 1'b0;
      first_fail_ch <= '0;
    end else begin
      any_fail <= |fail_now | (any_fail & ~clr_fail);
      if (!any_fail && |fail_now) first_fail_ch <= ff_idx;
      else if (clr_fail && !(|fail_now)) first_fail_ch <= '0;
    end
endmodule

// File: tb/tb_event_watchdog.sv
// tb_event_watchdog: table-driven and directed checks of event_watchdog with 4 channels, 20-bit counters.
module tb_event_watchdog;
  localparam logic [19:0] DC = 20'hFFFFF;
  logic        clk = 1'b0, rst_n = 1'b0, clr_fail = 1'b0;
  logic [3:0]  arm = '0, lvl_mode = '0, evt = '0, abort = '0;
  logic [19:0] budget = '0;
  logic [3:0]  busy, pass, timeout, done;
  logic [79:0] lat;
  logic        any_fail;
  logic [1:0]  first_fail_ch;
  int n_chk = 0, n_fail = 0, d0 = 0;

  typedef struct {
    logic rst_n; logic [3:0] arm, lvl, evt, abort; logic clr; logic [19:0] bud;
    logic [3:0] e_busy, e_pass, e_to, e_done; logic e_af; logic [19:0] e_lat0;
  } vec_t;
  vec_t tbl[19];

  event_watchdog #(.NUM_CH(4), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .budget(budget), .lvl_mode(lvl_mode),
    .evt(evt), .abort(abort), .clr_fail(clr_fail), .busy(busy), .pass(pass),
    .timeout(timeout), .done(done), .lat(lat), .any_fail(any_fail),
    .first_fail_ch(first_fail_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (done[0]) d0++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(logic r, logic [3:0] a, logic [3:0] l, logic [3:0] e, logic [3:0] ab,
                             logic c, logic [19:0] b, logic [3:0] eb, logic [3:0] ep, logic [3:0] et,
                             logic [3:0] ed, logic ea, logic [19:0] el);
    vec_t x;
    x.rst_n = r; x.arm = a; x.lvl = l; x.evt = e; x.abort = ab; x.clr = c; x.bud = b;
    x.e_busy = eb; x.e_pass = ep; x.e_to = et; x.e_done = ed; x.e_af = ea; x.e_lat0 = el;
    return x;
  endfunction

  task automatic idle(input int n);
    arm = '0; abort = '0; clr_fail = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[2]  = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[3]  = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[4]  = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[5]  = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    tbl[6]  = v(1, 0, 0, 1, 0, 0, 5, 0, 1, 0, 1, 0, 5);
    tbl[7]  = v(1, 0, 0, 0, 0, 0, 5, 0, 1, 0, 0, 0, 5);
    tbl[8]  = v(1, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, DC);
    tbl[9]  = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, DC);
    tbl[10] = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, DC);
    tbl[11] = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, DC);
    tbl[12] = v(1, 0, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, DC);
    tbl[13] = v(1, 0, 0, 0, 0, 0, 5, 0, 0, 1, 1, 1, 0);
    tbl[14] = v(1, 0, 0, 1, 0, 0, 5, 0, 0, 1, 0, 1, 0);
    tbl[15] = v(1, 0, 0, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0);
    tbl[16] = v(1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, DC);
    tbl[17] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    tbl[18] = v(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 19; r++) begin
      rst_n = tbl[r].rst_n; arm = tbl[r].arm; lvl_mode = tbl[r].lvl; evt = tbl[r].evt;
      abort = tbl[r].abort; clr_fail = tbl[r].clr; budget = tbl[r].bud;
      tick();
      chk($sformatf("row%0d busy", r), 32'(busy), 32'(tbl[r].e_busy));
      chk($sformatf("row%0d pass", r), 32'(pass), 32'(tbl[r].e_pass));
      chk($sformatf("row%0d timeout", r), 32'(timeout), 32'(tbl[r].e_to));
      chk($sformatf("row%0d done", r), 32'(done), 32'(tbl[r].e_done));
      chk($sformatf("row%0d any_fail", r), 32'(any_fail), 32'(tbl[r].e_af));
      if (tbl[r].e_lat0 != DC) chk($sformatf("row%0d lat0", r), 32'(lat[19:0]), 32'(tbl[r].e_lat0));
    end
    // edge pass at 37 cycles
    idle(1);
    arm = 4'b0001; lvl_mode = '0; budget = 20'd100; tick();
    idle(36);
    chk("edge37 busy before hit", 32'(busy[0]), 1);
    evt[0] = 1'b1; tick();
    chk("edge37 pass", 32'(pass[0]), 1);
    chk("edge37 done", 32'(done[0]), 1);
    chk("edge37 lat", 32'(lat[19:0]), 37);
    chk("edge37 any_fail", 32'(any_fail), 0);
    evt[0] = 1'b0; tick();
    chk("edge37 done one cycle", 32'(done[0]), 0);
    // held-high event: edge mode times out, level mode passes at once
    evt[1] = 1'b1; tick();
    arm = 4'b0010; budget = 20'd10; tick();
    idle(9);
    chk("edge held busy", 32'(busy[1]), 1);
    chk("edge held no timeout yet", 32'(timeout[1]), 0);
    tick();
    chk("edge held timeout", 32'(timeout[1]), 1);
    chk("edge held done", 32'(done[1]), 1);
    chk("edge held any_fail", 32'(any_fail), 1);
    chk("edge held first_fail_ch", 32'(first_fail_ch), 1);
    arm = 4'b0010; lvl_mode = 4'b0010; tick();
    chk("level arm busy", 32'(busy[1]), 1);
    idle(1);
    chk("level pass", 32'(pass[1]), 1);
    chk("level lat", 32'(lat[39:20]), 1);
    evt = '0; lvl_mode = '0; clr_fail = 1'b1; tick();
    chk("clear after level", 32'(any_fail), 0);
    // simultaneous fails on ch2/ch3, later ch1
    arm = 4'b1100; budget = 20'd20; tick();
    idle(2);
    arm = 4'b0010; tick();
    idle(16);
    chk("sim no timeout at 19", 32'(timeout), 0);
    tick();
    chk("sim timeout 2,3", 32'(timeout), 32'b1100);
    chk("sim done 2,3", 32'(done), 32'b1100);
    chk("sim first_fail_ch", 32'(first_fail_ch), 2);
    idle(3);
    chk("sim ch1 timeout", 32'(timeout[1]), 1);
    chk("sim first_fail_ch held", 32'(first_fail_ch), 2);
    clr_fail = 1'b1; tick();
    chk("sim clr any_fail", 32'(any_fail), 0);
    chk("sim clr first_fail_ch", 32'(first_fail_ch), 0);
    // abort then re-arm mid-ARMED
    arm = 4'b0001; budget = 20'd100; tick();
    idle(5);
    d0 = 0;
    abort = 4'b0001; tick();
    chk("abort busy", 32'(busy[0]), 0);
    chk("abort pass/timeout", 32'({pass[0], timeout[0]}), 0);
    arm = 4'b0001; abort = '0; tick();
    idle(50);
    arm = 4'b0001; tick();
    idle(9);
    evt[0] = 1'b1; tick();
    chk("rearm pass", 32'(pass[0]), 1);
    chk("rearm lat", 32'(lat[19:0]), 10);
    evt[0] = 1'b0; idle(2);
    chk("rearm done count", 32'(d0), 1);
    // reset while ch0 armed and any_fail set
    arm = 4'b1000; budget = 20'd1; tick();
    idle(1);
    chk("pre-reset any_fail", 32'(any_fail), 1);
    arm = 4'b0001; budget = 20'd100; tick();
    idle(3);
    d0 = 0;
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("reset busy", 32'(busy), 0);
    chk("reset pass", 32'(pass), 0);
    chk("reset timeout", 32'(timeout), 0);
    chk("reset done", 32'(done), 0);
    chk("reset any_fail", 32'(any_fail), 0);
    chk("reset first_fail_ch", 32'(first_fail_ch), 0);
    chk("reset lat", 32'(lat != '0), 0);
    idle(2);
    chk("reset no done", 32'(d0), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
